// File: rtl/timer_pkg.sv
// timer_pkg: register byte offsets and TCON bit indices shared by the timer files
package timer_pkg;
  localparam logic [3:0] TH_OFS      = 4'h0;
  localparam logic [3:0] TL_OFS      = 4'h4;
  localparam logic [3:0] TCON_OFS    = 4'h8;
  localparam logic [3:0] SYSTICK_OFS = 4'hC;
  localparam int TCON_EN   = 0;
  localparam int TCON_IE   = 1;
  localparam int TCON_STAT = 2;
endpackage

// File: rtl/timer_irq_if.sv
// timer_irq_if: data-memory bus slice seen by the timer
// addr/wdata/mem_wr/mem_rd driven by the CPU (master); rdata/sel returned by the timer (slave)
interface timer_irq_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_wr;
  logic        mem_rd;
  logic        sel;
  modport master(output addr, wdata, mem_wr, mem_rd, input rdata, sel);
  modport slave(input addr, wdata, mem_wr, mem_rd, output rdata, sel);
endinterface

// File: rtl/tick_divider.sv
// tick_divider: prescaler producing one tick every PRESCALE enabled cycles
// clk/rst_n clock and async reset; i_en advances (else holds) the count; o_tick marks the last count
module tick_divider #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);
  logic [15:0] r_cnt;
  assign o_tick = i_en && r_cnt == 16'(PRESCALE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped interval timer with reload, pending status and user-mode irq
// clk/rst_n clock and async reset; bus register access (TH, TL, TCON, SYSTICK);
// pc_kernel is PC[31] of the current instruction; irq goes to the control unit
module timer_irq
  import timer_pkg::*;
#(
  parameter int          PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_irq_if.slave  bus,
  input  logic        pc_kernel,
  output logic        irq
);
  logic [31:0] r_th, r_tl, r_systick, w_tcon;
  logic        r_en, r_ie, r_stat;
  logic        w_tick, w_wr, w_wr_th, w_wr_tl, w_wr_tcon, w_ovf, w_set_stat;
  logic [3:0]  w_ofs;
  tick_divider #(.PRESCALE(PRESCALE)) u_div (.clk(clk), .rst_n(rst_n), .i_en(r_en), .o_tick(w_tick));
  assign bus.sel    = bus.addr[31:4] == BASE_ADDR[31:4];
  assign w_ofs      = {bus.addr[3:2], 2'b00};
  assign w_wr       = bus.mem_wr & bus.sel;
  assign w_wr_th    = w_wr && w_ofs == TH_OFS;
  assign w_wr_tl    = w_wr && w_ofs == TL_OFS;
  assign w_wr_tcon  = w_wr && w_ofs == TCON_OFS;
  assign w_ovf      = w_tick & (&r_tl);
  // a software TL write on the overflow edge pre-empts both the reload and the status set
  assign w_set_stat = w_ovf & r_ie & ~w_wr_tl;
  assign irq        = r_stat & r_ie & ~pc_kernel;
  always_comb begin
    w_tcon            = '0;
    w_tcon[TCON_EN]   = r_en;
    w_tcon[TCON_IE]   = r_ie;
    w_tcon[TCON_STAT] = r_stat;
  end
  assign bus.rdata = !(bus.mem_rd && bus.sel) ? '0 :
                     w_ofs == TH_OFS   ? r_th :
                     w_ofs == TL_OFS   ? r_tl :
                     w_ofs == TCON_OFS ? w_tcon : r_systick;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_systick <= '0;
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_stat    <= 1'b0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (w_wr_th) r_th <= bus.wdata;
      if (w_wr_tl) r_tl <= bus.wdata;
      else if (w_tick) r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      if (w_wr_tcon) begin
        r_en <= bus.wdata[TCON_EN];
        r_ie <= bus.wdata[TCON_IE];
      end
      // an overflow on the same edge as a clearing TCON write still leaves STAT set
      r_stat <= (w_wr_tcon ? bus.wdata[TCON_STAT] : r_stat) | w_set_stat;
    end
endmodule
